// File: rtl/sync_frame_fifo_pkg.sv
// sync_frame_fifo_pkg: shared defaults and pointer helpers for the frame FIFO.
// The helpers work on pointers zero-extended to MAX_PTR_W bits; the caller
// passes the real pointer width so one set of functions serves any WIDTH.
package sync_frame_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_SIZE   = 16;
    localparam int MAX_PTR_W  = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    // Mask covering the low w bits of a wide pointer.
    function automatic ptr_t ptr_mask(input int unsigned w);
        return (ptr_t'(1) << w) - ptr_t'(1);
    endfunction

    // Increment modulo 2^w.
    function automatic ptr_t ptr_inc(input ptr_t p, input int unsigned w);
        return (p + ptr_t'(1)) & ptr_mask(w);
    endfunction

    // Full: wrap bits differ, all lower bits equal.
    function automatic logic ptr_full(input ptr_t a, input ptr_t b, input int unsigned w);
        return ((a ^ b) & ptr_mask(w)) == (ptr_t'(1) << (w - 1));
    endfunction

    // Empty: pointers identical including the wrap bit.
    function automatic logic ptr_empty(input ptr_t a, input ptr_t b);
        return a == b;
    endfunction

    // Entries between two pointers, modulo 2^w.
    function automatic ptr_t ptr_used(input ptr_t a, input ptr_t b, input int unsigned w);
        return (a - b) & ptr_mask(w);
    endfunction

endpackage

// File: rtl/fifo_dp_ram.sv
// fifo_dp_ram: simple dual-port storage, one write port and one read port.
// Read port is registered by default; with SYNC_FRAME_FIFO_FWFT_EN defined it
// is combinational so the head entry falls through.
module fifo_dp_ram #(
    parameter int DW    = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    output logic          rlast_peek_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Storage array write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Top bit of the entry at the read address: the frame-last flag.
    assign rlast_peek_o = mem_q[raddr_i][DW-1];

`ifdef SYNC_FRAME_FIFO_FWFT_EN
    logic unused_rd_ctrl;
    assign unused_rd_ctrl = re_i ^ arst_n;
    assign rdata_o        = mem_q[raddr_i];
`else
    logic [DW-1:0] rdata_q;

    // Registered read; holds its value when no read is issued.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_frame_fifo.sv
// sync_frame_fifo: store-and-forward frame FIFO. Words are written at a
// speculative pointer and become readable only when the frame's last word
// commits; bad or overflowing frames roll the speculative pointer back.
// Optional macro SYNC_FRAME_FIFO_FWFT_EN selects first-word-fall-through reads.
module sync_frame_fifo
    import sync_frame_fifo_pkg::*;
#(
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  SIZE      = DEF_SIZE,
    localparam int WIDTH     = $clog2(SIZE) + 1,
    parameter int  AFULL_THR = SIZE - 2
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              w_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              w_last,
    input  logic              w_bad,
    input  logic              r_en,
    output logic [DATA_W-1:0] data_out,
    output logic              r_last,
    output logic              r_valid,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [WIDTH-1:0]  frame_cnt,
    output logic              drop,
    output logic              drop_ovf
);

    logic [WIDTH-1:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic             ovf_q, ovf_d;
    logic             full_q, full_d, afull_q, afull_d, empty_q, empty_d;
    logic             drop_q, drop_d, drop_ovf_q, drop_ovf_d;
    logic             ram_we, pop, commit, head_last;
    logic [DATA_W:0]  ram_rdata;
    ptr_t             wptr_inc_w, rptr_inc_w, used_w;
    logic [WIDTH-1:0] wptr_inc, rptr_inc;

    assign wptr_inc_w = ptr_inc(ptr_t'(wptr_q), WIDTH);
    assign rptr_inc_w = ptr_inc(ptr_t'(rptr_q), WIDTH);
    assign wptr_inc   = wptr_inc_w[WIDTH-1:0];
    assign rptr_inc   = rptr_inc_w[WIDTH-1:0];

    // Write/commit/rollback and read decisions, all against start-of-cycle flags.
    always_comb begin
        wptr_d      = wptr_q;
        cptr_d      = cptr_q;
        rptr_d      = rptr_q;
        ovf_d       = ovf_q;
        drop_d      = 1'b0;
        drop_ovf_d  = 1'b0;
        ram_we      = 1'b0;
        commit      = 1'b0;
        pop         = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (w_en) begin
            if (full_q || ovf_q) begin
                // Overflowing frame: discard words until its last, then roll back.
                if (w_last) begin
                    wptr_d     = cptr_q;
                    ovf_d      = 1'b0;
                    drop_d     = 1'b1;
                    drop_ovf_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (w_last && w_bad) begin
                wptr_d = cptr_q;
                drop_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                wptr_d = wptr_inc;
                if (w_last) begin
                    cptr_d = wptr_inc;
                    commit = 1'b1;
                end
            end
        end
        if (r_en && !empty_q) begin
            pop    = 1'b1;
            rptr_d = rptr_inc;
        end
        case ({commit, pop && head_last})
            2'b10:   frame_cnt_d = frame_cnt_q + WIDTH'(1);
            2'b01:   frame_cnt_d = frame_cnt_q - WIDTH'(1);
            default: frame_cnt_d = frame_cnt_q;
        endcase
    end

    // Status flags derived from next-state pointers, registered below.
    always_comb begin
        used_w  = ptr_used(ptr_t'(wptr_d), ptr_t'(rptr_d), WIDTH);
        full_d  = ptr_full(ptr_t'(wptr_d), ptr_t'(rptr_d), WIDTH);
        empty_d = ptr_empty(ptr_t'(cptr_d), ptr_t'(rptr_d));
        afull_d = used_w >= ptr_t'(AFULL_THR);
    end

    // Pointer, counter and flag state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q      <= '0;
            cptr_q      <= '0;
            rptr_q      <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            empty_q     <= 1'b1;
            drop_q      <= 1'b0;
            drop_ovf_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            cptr_q      <= cptr_d;
            rptr_q      <= rptr_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            empty_q     <= empty_d;
            drop_q      <= drop_d;
            drop_ovf_q  <= drop_ovf_d;
        end
    end

    fifo_dp_ram #(
        .DW    (DATA_W + 1),
        .DEPTH (SIZE)
    ) u_ram (
        .clk          (clk),
        .arst_n       (arst_n),
        .we_i         (ram_we),
        .waddr_i      (wptr_q[WIDTH-2:0]),
        .wdata_i      ({w_last, data_in}),
        .re_i         (pop),
        .raddr_i      (rptr_q[WIDTH-2:0]),
        .rdata_o      (ram_rdata),
        .rlast_peek_o (head_last)
    );

`ifdef SYNC_FRAME_FIFO_FWFT_EN
    assign data_out = empty_q ? '0   : ram_rdata[DATA_W-1:0];
    assign r_last   = empty_q ? 1'b0 : ram_rdata[DATA_W];
    assign r_valid  = !empty_q;
`else
    logic rvalid_q;

    // Read data appears one cycle after an accepted pop.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop;
        end
    end

    assign data_out = ram_rdata[DATA_W-1:0];
    assign r_last   = ram_rdata[DATA_W];
    assign r_valid  = rvalid_q;
`endif

    assign full        = full_q;
    assign almost_full = afull_q;
    assign empty       = empty_q;
    assign frame_cnt   = frame_cnt_q;
    assign drop        = drop_q;
    assign drop_ovf    = drop_ovf_q;

endmodule

// File: tb/tb_sync_frame_fifo.sv
// tb_sync_frame_fifo: directed bench for sync_frame_fifo (standard read mode,
// DATA_W=8, SIZE=16, AFULL_THR=14).
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_sync_frame_fifo;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       w_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       w_last = 1'b0;
  logic       w_bad = 1'b0;
  logic       r_en = 1'b0;
  logic [7:0] data_out;
  logic       r_last, r_valid, full, almost_full, empty, drop, drop_ovf;
  logic [4:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  sync_frame_fifo #(.DATA_W(8), .SIZE(16), .AFULL_THR(14)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .w_en        (w_en),
    .data_in     (data_in),
    .w_last      (w_last),
    .w_bad       (w_bad),
    .r_en        (r_en),
    .data_out    (data_out),
    .r_last      (r_last),
    .r_valid     (r_valid),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .frame_cnt   (frame_cnt),
    .drop        (drop),
    .drop_ovf    (drop_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic last, input logic bad);
    w_en    = 1'b1;
    data_in = d;
    w_last  = last;
    w_bad   = bad;
    tick();
    w_en   = 1'b0;
    w_last = 1'b0;
    w_bad  = 1'b0;
  endtask

  task automatic reset_flags(input string tag);
    `CHK({tag, "_empty"}, empty, 1);
    `CHK({tag, "_full"}, full, 0);
    `CHK({tag, "_afull"}, almost_full, 0);
    `CHK({tag, "_rvalid"}, r_valid, 0);
    `CHK({tag, "_dout"}, data_out, 8'h00);
    `CHK({tag, "_rlast"}, r_last, 0);
    `CHK({tag, "_fcnt"}, frame_cnt, 0);
    `CHK({tag, "_drop"}, drop, 0);
    `CHK({tag, "_dropovf"}, drop_ovf, 0);
  endtask

  initial begin
    logic [7:0] exp_d;
    logic       exp_l;

    // Reset state
    tick();
    tick();
    reset_flags("rst");
    arst_n = 1'b1;
    tick();

    // Good 3-word frame, then 3 reads
    wr(8'h11, 0, 0);
    `CHK("f1_empty_w1", empty, 1);
    wr(8'h22, 0, 0);
    `CHK("f1_empty_w2", empty, 1);
    wr(8'h33, 1, 0);
    `CHK("f1_empty_commit", empty, 0);
    `CHK("f1_fcnt_commit", frame_cnt, 1);
    r_en = 1'b1;
    tick();
    `CHK("f1_rv0", r_valid, 1);
    `CHK("f1_d0", data_out, 8'h11);
    `CHK("f1_l0", r_last, 0);
    `CHK("f1_fc0", frame_cnt, 1);
    tick();
    `CHK("f1_d1", data_out, 8'h22);
    `CHK("f1_l1", r_last, 0);
    tick();
    `CHK("f1_d2", data_out, 8'h33);
    `CHK("f1_l2", r_last, 1);
    `CHK("f1_fc2", frame_cnt, 0);
    `CHK("f1_empty_end", empty, 1);
    r_en = 1'b0;
    tick();
    `CHK("f1_rv_idle", r_valid, 0);
    `CHK("f1_hold", data_out, 8'h33);

    // Bad frame rolled back
    for (int i = 0; i < 3; i++) wr(8'hA0 + 8'(i), 0, 0);
    wr(8'hA3, 1, 1);
    `CHK("bad_drop", drop, 1);
    `CHK("bad_dropovf", drop_ovf, 0);
    `CHK("bad_empty", empty, 1);
    `CHK("bad_fcnt", frame_cnt, 0);
    tick();
    `CHK("bad_drop_pulse", drop, 0);

    // Two 8-word frames fill the FIFO exactly, then overflow
    for (int i = 0; i < 16; i++) begin
      wr((i < 8) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 8), (i == 7) || (i == 15), 0);
      `CHK($sformatf("fill_af%0d", i), almost_full, (i + 1) >= 14);
      `CHK($sformatf("fill_full%0d", i), full, i == 15);
    end
    `CHK("fill_fcnt", frame_cnt, 2);
    wr(8'h60, 0, 0);
    `CHK("ovf_full", full, 1);
    `CHK("ovf_nodrop", drop, 0);
    wr(8'h61, 1, 0);
    `CHK("ovf_drop", drop, 1);
    `CHK("ovf_dropovf", drop_ovf, 1);
    `CHK("ovf_fcnt", frame_cnt, 2);
    r_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_d = (i < 8) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 8);
      exp_l = (i == 7) || (i == 15);
      checks++;
      if (data_out !== exp_d) begin
        errors++;
        $error("FAIL rb_d%0d observed=%0h expected=%0h", i, data_out, exp_d);
      end
      checks++;
      if (r_last !== exp_l) begin
        errors++;
        $error("FAIL rb_l%0d observed=%0h expected=%0h", i, r_last, exp_l);
      end
      `CHK($sformatf("rb_fc%0d", i), frame_cnt, (i < 7) ? 2 : ((i < 15) ? 1 : 0));
    end
    r_en = 1'b0;
    `CHK("rb_empty", empty, 1);

    // 20-word frame never commits
    for (int i = 0; i < 20; i++) begin
      wr(8'h70 + 8'(i), i == 19, 0);
      `CHK($sformatf("long_empty%0d", i), empty, 1);
      checks++;
      if (full !== ((i >= 15) && (i < 19))) begin
        errors++;
        $error("FAIL long_full%0d observed=%0h expected=%0h", i, full, (i >= 15) && (i < 19));
      end
      checks++;
      if (drop !== (i == 19)) begin
        errors++;
        $error("FAIL long_drop%0d observed=%0h expected=%0h", i, drop, i == 19);
      end
    end
    `CHK("long_dropovf", drop_ovf, 1);
    `CHK("long_fcnt", frame_cnt, 0);

    // Read and write together while full: read wins, write overflows
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), i == 15, 0);
    `CHK("rw_full", full, 1);
    `CHK("rw_fcnt", frame_cnt, 1);
    r_en    = 1'b1;
    w_en    = 1'b1;
    data_in = 8'h99;
    tick();
    r_en = 1'b0;
    w_en = 1'b0;
    `CHK("rw_rv", r_valid, 1);
    `CHK("rw_d", data_out, 8'h80);
    `CHK("rw_full_after", full, 0);
    `CHK("rw_nodrop", drop, 0);
    wr(8'h9A, 1, 0);
    `CHK("rw_drop", drop, 1);
    `CHK("rw_dropovf", drop_ovf, 1);
    `CHK("rw_fcnt2", frame_cnt, 1);
    r_en = 1'b1;
    for (int i = 1; i < 16; i++) begin
      tick();
      `CHK($sformatf("rw_d%0d", i), data_out, 8'h80 + 8'(i));
      `CHK($sformatf("rw_l%0d", i), r_last, i == 15);
    end
    r_en = 1'b0;
    `CHK("rw_fcnt_end", frame_cnt, 0);
    `CHK("rw_empty_end", empty, 1);

    // Commit and last-pop in the same cycle
    wr(8'hC1, 1, 0);
    `CHK("cp_fcnt1", frame_cnt, 1);
    r_en    = 1'b1;
    w_en    = 1'b1;
    data_in = 8'hC2;
    w_last  = 1'b1;
    tick();
    r_en   = 1'b0;
    w_en   = 1'b0;
    w_last = 1'b0;
    `CHK("cp_fcnt_same", frame_cnt, 1);
    `CHK("cp_d", data_out, 8'hC1);
    `CHK("cp_l", r_last, 1);
    `CHK("cp_empty", empty, 0);
    r_en = 1'b1;
    tick();
    `CHK("cp_d2", data_out, 8'hC2);
    `CHK("cp_fcnt0", frame_cnt, 0);
    `CHK("cp_empty2", empty, 1);
    tick();
    r_en = 1'b0;
    `CHK("ue_rv", r_valid, 0);
    `CHK("ue_hold", data_out, 8'hC2);

    // Reset mid-frame with two committed frames
    wr(8'hD0, 0, 0);
    wr(8'hD1, 1, 0);
    wr(8'hD2, 1, 0);
    wr(8'hD3, 0, 0);
    `CHK("mr_fcnt", frame_cnt, 2);
    arst_n = 1'b0;
    #2;
    reset_flags("mr");
    tick();
    arst_n = 1'b1;
    tick();
    `CHK("mr_empty_post", empty, 1);
    wr(8'hE5, 1, 0);
    `CHK("mr_empty_commit", empty, 0);
    `CHK("mr_fcnt1", frame_cnt, 1);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    `CHK("mr_rv", r_valid, 1);
    `CHK("mr_d", data_out, 8'hE5);
    `CHK("mr_l", r_last, 1);
    `CHK("mr_fcnt0", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_frame_fifo.md
# sync_frame_fifo

Single-clock, parametrised store-and-forward frame FIFO for the MAC datapath. It sits between the receive framer and the host-side reader. A frame becomes visible to the reader only after its last word is written with a good status. Bad or overflowing frames are rolled back atomically, so the reader never sees a partial frame.

## Interface
Parameters:
- DATA_W, 8, data word width.
- SIZE, 16, entry count; power of 2, at least 4.
- WIDTH, $clog2(SIZE)+1, pointer width including the wrap bit; derived, not overridden.
- AFULL_THR, SIZE-2, almost_full asserts when used entries (speculative) ≥ AFULL_THR.

Ports:
- clk  in  1  single clock; all logic on posedge.
- arst_n  in  1  reset, asynchronous and active-low.
- w_en  in  1  write strobe.
- data_in  in  DATA_W  write data.
- w_last  in  1  qualifies w_en: last word of frame.
- w_bad  in  1  sampled only with w_en&w_last: 1 = discard frame.
- r_en  in  1  read/pop strobe.
- data_out  out  DATA_W  read data.
- r_last  out  1  data_out is the last word of its frame.
- r_valid  out  1  data_out/r_last valid this cycle.
- full  out  1  no free entry (speculative pointer vs read pointer).
- almost_full  out  1  see AFULL_THR.
- empty  out  1  no committed word to read.
- frame_cnt  out  WIDTH  committed frames not yet fully read.
- drop  out  1  one-cycle pulse: a frame was rolled back.
- drop_ovf  out  1  qualifies drop: 1 = overflow, 0 = w_bad.

## Operation
- Storage holds DATA_W+1 bits per entry: data plus the last flag.
- There are three WIDTH-bit pointers:
  - wptr: speculative write pointer.
  - cptr: committed write pointer.
  - rptr: read pointer.
- Full and empty use the wrap bit and increment mod 2^WIDTH:
  - full = (wptr[WIDTH-1] != rptr[WIDTH-1]) && low bits equal.
  - empty = (cptr == rptr).
- Write accepted: w_en && !full && !ovf. The entry is stored at wptr and wptr increments.
- Commit: accepted w_en & w_last & !w_bad sets cptr <= wptr+1 and increments frame_cnt.
- Bad frame: w_en & w_last & w_bad when !ovf and !full writes nothing. wptr <= cptr, drop=1, drop_ovf=0.
- Overflow: w_en while full or while ovf=1 sets ovf=1. The word is discarded.
  - On the next w_en&w_last (still discarded): wptr <= cptr, ovf <= 0, drop=1, drop_ovf=1.
  - w_bad is ignored in that cycle.
- Read accepted: r_en && !empty. The pop is defined under "Without the macro" and "With the macro" below.
- frame_cnt decrements when a popped entry has its last flag set. Simultaneous commit and last-pop leave frame_cnt unchanged.
- A frame longer than SIZE can never commit. It always ends in an overflow drop.
- r_en while empty is ignored. There is no underflow state and no pointer change.

## Timing
- Reset values (async assert, sync release on clk):
  - wptr = cptr = rptr = 0.
  - ovf = 0.
  - frame_cnt = 0.
  - empty = 1; full = 0; almost_full = 0.
  - r_valid = 0; data_out = 0; r_last = 0.
  - drop = 0; drop_ovf = 0.
- Reset mid-frame discards all content, including the partial frame.
- Status flags are registered from pointer state. They reflect a write or commit one cycle after the clk edge that accepted it.
- Commit-to-visible latency: empty deasserts on the cycle after the commit edge. Earliest read is the second cycle.
- Read and write in the same cycle are both evaluated against start-of-cycle flags:
  - When full, a same-cycle read does not allow the write. The write counts as overflow.
  - When empty, a same-cycle commit does not allow the read.
- A rollback and a read in the same cycle are independent. The read operates only on committed data.

## Configuration
- Macro: SYNC_FRAME_FIFO_FWFT_EN.
- Without the macro (standard mode):
  - Accepted r_en pops the entry.
  - data_out/r_last are registered and r_valid=1 on the next cycle. Read latency is 1.
  - r_valid is 0 otherwise.
  - data_out holds its last value when r_valid=0.
- With the macro (first-word-fall-through):
  - data_out/r_last show the head entry whenever !empty.
  - r_valid = !empty.
  - Accepted r_en pops, and the next entry appears on the following cycle.
  - Latency from commit to r_valid stays one cycle.

## Structure
- Package sync_frame_fifo_pkg holds:
  - default constants DEF_DATA_W=8 and DEF_SIZE=16;
  - the pointer-increment/full/empty compare functions, generic over WIDTH via parameterised class-free function arguments sized to the maximum width.
- Sub-module fifo_dp_ram: simple dual-port array, one write port, one read port.
  - Registered read in standard mode; combinational read in FWFT mode.
  - Width DATA_W+1, depth SIZE.
- Pointer and commit logic stays in sync_frame_fifo.

## Test plan
- Reset, write a 3-word frame (0x11,0x22,0x33) with good last, then 3 reads:
  - empty=1 until the cycle after commit;
  - data 0x11,0x22,0x33 with r_last only on 0x33;
  - frame_cnt 1→0.
- Write a 4-word frame with w_bad=1 on last:
  - drop=1, drop_ovf=0;
  - empty stays 1, frame_cnt=0, wptr returns to cptr.
- Commit two 8-word frames (SIZE=16), then write one more word:
  - full=1 and overflow;
  - on that frame's last: drop=1, drop_ovf=1;
  - both committed frames then read back intact.
- Write a 20-word frame into an empty FIFO: it never commits, drop_ovf=1 on last, empty=1 throughout.
- While full, assert r_en and w_en together:
  - the read succeeds;
  - the write counts as overflow.
  Separately, commit and pop a last word in the same cycle: frame_cnt unchanged.
- Assert arst_n=0 mid-frame with 2 committed frames: all flags return to reset values, and a subsequent 1-word frame reads back correctly.
